// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and sequencing controller for the five-stage MIPS
// pipeline. Generates PC / IF/ID load enables, the ID/EX bubble, stage flushes
// and a global hold while data memory is busy, with a sticky memory timeout.
module hazard_ctrl #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        br_taken,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_bubble,
    output logic        pipe_hold,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic [1:0]  state,
    output logic        err
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERROR    = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               err_q;
    logic               stall_inc, flush_inc, err_set;
    logic               hz;
    logic               run_eval;

    // Load-use hazard: the load in ID/EX writes a register the ID instruction reads.
    assign hz = ex_mem_read & (ex_rt != 5'd0) &
                ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

    // A released memory wait is handled exactly like a normal RUN cycle.
    assign run_eval = (state_q == RUN) | ((state_q == MEM_WAIT) & ~mem_busy);

    // Next-state and Mealy control outputs; reset forces the pipeline frozen.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        state_d     = state_q;
        wait_d      = wait_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        err_set     = 1'b0;

        if (!rst_n) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            state_d    = RUN;
            wait_d     = '0;
        end else if (run_eval) begin
            state_d = RUN;
            wait_d  = '0;
            if (br_taken) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                flush_inc   = 1'b1;
            end else if (mem_busy) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                pipe_hold  = 1'b1;
                stall_inc  = 1'b1;
                wait_d     = WAIT_W'(1);
                state_d    = MEM_WAIT;
            end else if (hz) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                stall_inc   = 1'b1;
            end
        end else if (state_q == MEM_WAIT) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
            if (wait_q < WAIT_W'(MAX_WAIT)) begin
                wait_d    = wait_q + WAIT_W'(1);
                stall_inc = 1'b1;
            end else begin
                state_d = ERROR;
                err_set = 1'b1;
            end
        end else begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            pipe_hold  = 1'b1;
        end
    end

    // State, wait counter, saturating statistics counters and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wait_q    <= '0;
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (stall_inc && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
            if (flush_inc && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'd1;
            if (err_set)
                err_q <= 1'b1;
        end
    end

    assign state = state_q;
    assign err   = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against a
// behavioural model of the pipeline controller rules.
module tb_hazard_ctrl;

    localparam int MAX_WAIT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
    logic        id_uses_rt = 1'b0, ex_mem_read = 1'b0, br_taken = 1'b0, mem_busy = 1'b0;
    logic        pc_write, ifid_write, idex_bubble, pipe_hold;
    logic        ifid_flush, idex_flush, exmem_flush, err;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 = running, 1 = waiting on memory, 2 = timed out
    int m_mode, m_waited, m_stalls, m_flushes;
    bit m_err;
    int n_mode, n_waited, n_stalls, n_flushes;
    bit n_err;
    bit e_pc, e_ifid, e_bub, e_hold, e_flush;

    hazard_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .br_taken(br_taken), .mem_busy(mem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .state(state), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs and next model state from the controller rules
    task automatic modelEval();
        bit hazard;
        hazard = ex_mem_read && ex_rt != 0 &&
                 (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
        e_pc = 1; e_ifid = 1; e_bub = 0; e_hold = 0; e_flush = 0;
        n_mode = m_mode; n_waited = m_waited; n_stalls = m_stalls;
        n_flushes = m_flushes; n_err = m_err;
        if (!rst_n) begin
            e_pc = 0; e_ifid = 0; e_hold = 1;
            n_mode = 0; n_waited = 0; n_stalls = 0; n_flushes = 0; n_err = 0;
        end else if (m_mode == 2) begin
            e_pc = 0; e_ifid = 0; e_hold = 1;
        end else if (m_mode == 1 && mem_busy) begin
            e_pc = 0; e_ifid = 0; e_hold = 1;
            if (m_waited < MAX_WAIT) begin
                n_waited = m_waited + 1;
                n_stalls = sat16(m_stalls + 1);
            end else begin
                n_mode = 2;
                n_err = 1;
            end
        end else begin
            n_mode = 0; n_waited = 0;
            if (br_taken) begin
                e_flush = 1;
                n_flushes = sat16(m_flushes + 1);
            end else if (mem_busy) begin
                e_pc = 0; e_ifid = 0; e_hold = 1;
                n_stalls = sat16(m_stalls + 1);
                n_waited = 1;
                n_mode = 1;
            end else if (hazard) begin
                e_pc = 0; e_ifid = 0; e_bub = 1;
                n_stalls = sat16(m_stalls + 1);
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic urt, input logic emr, input logic [4:0] ert,
                                 input logic br, input logic busy);
        rst_n = r; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        ex_mem_read = emr; ex_rt = ert; br_taken = br; mem_busy = busy;
        if (!r) begin
            m_mode = 0; m_waited = 0; m_stalls = 0; m_flushes = 0; m_err = 0;
        end
        #1;
        modelEval();
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".pc_write"},    32'(pc_write),    32'(e_pc));
        checkValue({tag, ".ifid_write"},  32'(ifid_write),  32'(e_ifid));
        checkValue({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(e_bub));
        checkValue({tag, ".pipe_hold"},   32'(pipe_hold),   32'(e_hold));
        checkValue({tag, ".ifid_flush"},  32'(ifid_flush),  32'(e_flush));
        checkValue({tag, ".idex_flush"},  32'(idex_flush),  32'(e_flush));
        checkValue({tag, ".exmem_flush"}, 32'(exmem_flush), 32'(e_flush));
        checkValue({tag, ".stall_cnt"},   32'(stall_cnt),   32'(m_stalls));
        checkValue({tag, ".flush_cnt"},   32'(flush_cnt),   32'(m_flushes));
        checkValue({tag, ".state"},       32'(state),       32'(m_mode));
        checkValue({tag, ".err"},         32'(err),         32'(m_err));
    endtask

    task automatic clockEdge();
        @(posedge clk);
        m_mode = n_mode; m_waited = n_waited; m_stalls = n_stalls;
        m_flushes = n_flushes; m_err = n_err;
        @(negedge clk);
    endtask

    task automatic cycle(input string tag, input bit chk, input logic r,
                         input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                         input logic emr, input logic [4:0] ert,
                         input logic br, input logic busy);
        applyStimulus(r, rs, rt, urt, emr, ert, br, busy);
        if (chk) checkOutput(tag);
        clockEdge();
    endtask

    initial begin
        int s0;
        m_mode = 0; m_waited = 0; m_stalls = 0; m_flushes = 0; m_err = 0;
        @(negedge clk);

        // Reset forces the frozen output pattern and clears everything
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset");
        checkValue("reset_hold", 32'(pipe_hold), 32'd1);
        clockEdge();
        cycle("idle", 1, 1, 0, 0, 0, 0, 0, 0, 0);

        // Load-use on rs gives one bubble, then defaults
        applyStimulus(1, 2, 0, 0, 1, 2, 0, 0);
        checkOutput("lu_rs");
        checkValue("lu_rs_bubble", 32'(idex_bubble), 32'd1);
        clockEdge();
        applyStimulus(1, 2, 0, 0, 0, 0, 0, 0);
        checkOutput("lu_after");
        checkValue("lu_stall1", 32'(stall_cnt), 32'd1);
        clockEdge();

        // Load to $0 and unread rt never stall; read rt does
        cycle("zero_rt", 1, 1, 0, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 1, 5, 0, 1, 5, 0, 0);
        checkOutput("rt_unused");
        checkValue("rt_unused_pc", 32'(pc_write), 32'd1);
        clockEdge();
        cycle("rt_used", 1, 1, 1, 5, 1, 1, 5, 0, 0);

        // Branch flush, then branch together with a hazard
        cycle("br", 1, 1, 0, 0, 0, 0, 0, 1, 0);
        checkValue("br_cnt", 32'(flush_cnt), 32'd1);
        s0 = m_stalls;
        applyStimulus(1, 3, 0, 0, 1, 3, 1, 0);
        checkOutput("br_hz");
        checkValue("br_hz_bubble", 32'(idex_bubble), 32'd0);
        clockEdge();
        checkValue("br_hz_stall", 32'(stall_cnt), 32'(s0));
        cycle("br_busy", 1, 1, 0, 0, 0, 0, 0, 1, 1);
        checkValue("br_busy_state", 32'(state), 32'd0);

        // Three busy cycles then release
        s0 = m_stalls;
        for (int i = 0; i < 3; i++) cycle("busy3", 1, 1, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("busy3_rel");
        checkValue("busy3_stall", 32'(stall_cnt), 32'(s0 + 3));
        clockEdge();
        checkValue("busy3_state", 32'(state), 32'd0);

        // Branch held through a wait is taken on the release cycle
        cycle("wait_br0", 1, 1, 0, 0, 0, 0, 0, 1, 1);
        cycle("wait_br1", 1, 1, 0, 0, 0, 0, 0, 0, 1);
        cycle("wait_br2", 1, 1, 0, 0, 0, 0, 0, 1, 1);
        cycle("wait_brrel", 1, 1, 0, 0, 0, 0, 0, 1, 0);

        // Timeout after 17 busy cycles, then reset recovers
        for (int i = 0; i < 17; i++) cycle("tmo", 1, 1, 0, 0, 0, 0, 0, 0, 1);
        checkValue("tmo_state", 32'(state), 32'd2);
        checkValue("tmo_err", 32'(err), 32'd1);
        s0 = m_stalls;
        cycle("err_stay", 1, 1, 2, 0, 0, 1, 2, 1, 0);
        checkValue("err_stall_frozen", 32'(stall_cnt), 32'(s0));
        cycle("err_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkValue("rst_state", 32'(state), 32'd0);
        checkValue("rst_err", 32'(err), 32'd0);
        checkValue("rst_stall", 32'(stall_cnt), 32'd0);

        // Reset in the middle of a wait
        cycle("mw_rel", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle("mw0", 1, 1, 0, 0, 0, 0, 0, 0, 1);
        cycle("mw1", 1, 1, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("mw_rst");
        clockEdge();

        // Sustained hazard saturates stall_cnt
        for (int i = 0; i < 65540; i++) cycle("sat", 0, 1, 3, 0, 0, 1, 3, 0, 0);
        checkValue("sat_stall", 32'(stall_cnt), 32'hFFFF);
        cycle("sat_hold", 1, 1, 3, 0, 0, 1, 3, 0, 0);
        checkValue("sat_stall2", 32'(stall_cnt), 32'hFFFF);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            cycle("rnd", 1, ($urandom_range(0, 63) != 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage MIPS pipeline. It drives the write-enable, bubble and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB buffers. It detects load-use hazards against the ID/EX stage, flushes on branches resolved in MEM, freezes the pipeline while data memory is busy, and flags a memory timeout. It sits beside the ID/EX buffer and gates its controls, plus those of every other stage buffer.

## Interface
- MAX_WAIT, 16: maximum consecutive mem_busy cycles tolerated in MEM_WAIT before ERROR (≥2).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  5  IF/ID instruction[25:21]
- id_rt  in  5  IF/ID instruction[20:16]
- id_uses_rt  in  1  decoded ID instruction reads rt (R-type, beq, sw)
- ex_mem_read  in  1  ID/EX MemRead output
- ex_rt  in  5  ID/EX Ins_2016 output (load destination)
- br_taken  in  1  EX/MEM Branch AND zero, resolved in MEM
- mem_busy  in  1  data memory not ready this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- idex_bubble  out  1  force all ID/EX control inputs to 0 this edge
- pipe_hold  out  1  ID/EX, EX/MEM, MEM/WB keep contents (load disabled)
- ifid_flush, idex_flush, exmem_flush  out  1 each  clear stage to NOP on this edge
- stall_cnt  out  16  saturating count of stall cycles
- flush_cnt  out  16  saturating count of branch flushes
- state  out  2  RUN=00, MEM_WAIT=01, ERROR=10
- err  out  1  sticky memory-timeout flag

## Operation
- Load-use hazard: hz = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- Default outputs: pc_write=1, ifid_write=1, all others 0.
- RUN evaluation is Mealy and combinational from state and inputs. Priority is br_taken > mem_busy > hz.
  - br_taken: ifid_flush=idex_flush=exmem_flush=1; pc_write=1 (PC takes branch target); flush_cnt+1; stay RUN.
  - mem_busy: pc_write=0, ifid_write=0, pipe_hold=1; stall_cnt+1; wait_cnt<=1; next MEM_WAIT.
  - hz: pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt+1; stay RUN. Exactly one bubble results, because the next cycle ID/EX holds the bubble (ex_mem_read=0).
  - none: defaults.
- MEM_WAIT:
  - mem_busy=1 and wait_cnt < MAX_WAIT: apply the freeze outputs; wait_cnt+1; stall_cnt+1.
  - mem_busy=1 and wait_cnt == MAX_WAIT: apply the freeze outputs; next ERROR; err<=1.
  - mem_busy=0: evaluate exactly as RUN in the same cycle, including br/hz priority and next-state. A branch held in EX/MEM during the wait is therefore acted on in the release cycle.
  - br_taken and hz are ignored while frozen.
- ERROR: pc_write=0, ifid_write=0, pipe_hold=1 permanently; err=1; counters frozen; exit only by reset.
- Counters saturate at 16'hFFFF; no wrap.
- wait_cnt width is clog2(MAX_WAIT+1). It is internal and cleared on entry to RUN.

## Timing
- Reset (rst_n=0, asynchronous):
  - state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, err=0.
  - While rst_n=0, the outputs are forced: pc_write=0, ifid_write=0, pipe_hold=1, idex_bubble=0, all flushes 0.
- Release is synchronous to the next rising edge. The first cycle after release is RUN evaluation.
- Reset mid-MEM_WAIT or in ERROR: state is immediately RUN and err clears.
- Latency: hazard, branch and memory responses are zero-cycle, on the same-cycle outputs sampled by the buffers at the next edge. Counters and state update on that edge.
- Simultaneous events:
  - br_taken with hz: flush only, no bubble, stall_cnt unchanged.
  - br_taken with mem_busy in RUN: flush wins, and mem_busy is re-evaluated next cycle.
- ex_rt=0 never produces a stall.

## Test plan
- lw $2 in ID/EX (ex_mem_read=1, ex_rt=2), id_rs=2 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt=1; next cycle all defaults.
- ex_rt=0 with ex_mem_read=1, id_rs=0 -> no stall. ex_rt=5, id_rt=5, id_uses_rt=0 -> no stall.
- br_taken=1 for one cycle -> all three flushes=1, pc_write=1, flush_cnt=1. br_taken together with hz -> flushes only, idex_bubble=0.
- mem_busy high for 3 cycles (MAX_WAIT=16) -> pipe_hold=1 for 3 cycles, state=01 during the wait, stall_cnt=3. On the release cycle, outputs are defaults and state returns to 00.
- mem_busy held for 17 cycles -> state=10 and err=1 after the 17th edge, hold stays asserted, counters stop. Then rst_n low for one cycle -> state=00, err=0, counters 0.
- Drive stall_cnt to 16'hFFFF via sustained hazards -> it stays 16'hFFFF.
